// File: rtl/sorter_pkg.sv
// sorter_pkg: shared merger state encoding and size-counter width.
package sorter_pkg;
  localparam int SIZE_WIDTH = 16;
  typedef enum logic [2:0] {IDLE, MERGE, DRAIN_A, DRAIN_B, FINISH} merge_state_t;
endpackage

// File: rtl/axi_stream_if.sv
// axi_stream: valid/ready stream carrying data and tlast.
interface axi_stream #(parameter int DATA_WIDTH = 32);
  logic                  valid;
  logic                  ready;
  logic                  tlast;
  logic [DATA_WIDTH-1:0] data;
  modport master(output valid, data, tlast, input ready);
  modport slave(input valid, data, tlast, output ready);
endinterface

// File: rtl/merger_select.sv
// merger_select: picks A or B by key; descending order when SORTER_MERGE_DESCENDING_EN is defined.
module merger_select #(parameter int DATA_WIDTH = 32) (
  input  logic [DATA_WIDTH-1:0] key_a,
  input  logic [DATA_WIDTH-1:0] key_b,
  output logic                  take_a
);
  // Ties go to A in both orders to keep the merge stable.
`ifdef SORTER_MERGE_DESCENDING_EN
  assign take_a = key_a >= key_b;
`else
  assign take_a = key_a <= key_b;
`endif
endmodule

// File: rtl/merger_core.sv
// merger_core: merges two sorted streams into one through a single output register.
// Merge order is selected by SORTER_MERGE_DESCENDING_EN inside merger_select.
module merger_core
  import sorter_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_SORT_LENGTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [SIZE_WIDTH-1:0] chunk_size_a,
  input  logic [SIZE_WIDTH-1:0] chunk_size_b,
  axi_stream.slave              input_a,
  axi_stream.slave              input_b,
  axi_stream.master             merged_data,
  output logic                  done
);
  merge_state_t state, next_state;
  logic [SIZE_WIDTH-1:0] rem_a, rem_b;
  logic [SIZE_WIDTH:0]   total;
  logic [DATA_WIDTH-1:0] out_data;
  logic out_valid, out_last, out_free, take_a, both_valid, pop_a, pop_b;

  if (MAX_SORT_LENGTH < 1) begin : g_bad_len
    $error("MAX_SORT_LENGTH must be positive");
  end

  merger_select #(.DATA_WIDTH(DATA_WIDTH)) u_select (
    .key_a (input_a.data),
    .key_b (input_b.data),
    .take_a(take_a)
  );

  // No pops while reset is held, so nothing is taken from the FIFOs and then dropped.
  assign out_free   = reset && (!out_valid || merged_data.ready);
  assign both_valid = input_a.valid && input_b.valid;
  assign total      = {1'b0, rem_a} + {1'b0, rem_b};

  always_ff @(posedge clock)
    if (!reset) state <= IDLE;
    else state <= next_state;

  always_comb begin
    next_state = state;
    pop_a      = 1'b0;
    pop_b      = 1'b0;
    case (state)
      IDLE:
        if (start)
          next_state = chunk_size_a != '0 ? (chunk_size_b != '0 ? MERGE : DRAIN_A)
                                          : (chunk_size_b != '0 ? DRAIN_B : FINISH);
      MERGE: begin
        pop_a = out_free && both_valid && take_a;
        pop_b = out_free && both_valid && !take_a;
        next_state = pop_a && rem_a == 1 ? DRAIN_B : pop_b && rem_b == 1 ? DRAIN_A : MERGE;
      end
      DRAIN_A: begin
        pop_a = out_free && input_a.valid;
        next_state = pop_a && rem_a == 1 ? FINISH : DRAIN_A;
      end
      DRAIN_B: begin
        pop_b = out_free && input_b.valid;
        next_state = pop_b && rem_b == 1 ? FINISH : DRAIN_B;
      end
      FINISH: next_state = out_valid ? FINISH : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock)
    if (!reset) begin
      rem_a     <= '0;
      rem_b     <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      done      <= 1'b0;
    end else begin
      done <= state == FINISH && !out_valid;
      if (state == IDLE && start) begin
        rem_a <= chunk_size_a;
        rem_b <= chunk_size_b;
      end else begin
        if (pop_a) rem_a <= rem_a - 1'b1;
        if (pop_b) rem_b <= rem_b - 1'b1;
      end
      if (pop_a || pop_b) begin
        out_valid <= 1'b1;
        out_data  <= pop_a ? input_a.data : input_b.data;
        out_last  <= total == (SIZE_WIDTH+1)'(1);
      end else if (merged_data.ready) out_valid <= 1'b0;
    end

  assign input_a.ready     = pop_a;
  assign input_b.ready     = pop_b;
  assign merged_data.valid = out_valid;
  assign merged_data.data  = out_data;
  assign merged_data.tlast = out_last;
endmodule
